// File: rtl/pwm_dt_multi.sv
// Multi-channel complementary PWM with run-time dead-time; duty and dead-time
// are shadowed and only take effect at the period boundary.
module pwm_dt_multi #(
    parameter int WIDTH  = 12,
    parameter int NUM_CH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH*WIDTH-1:0] duty,
    input  logic [WIDTH-1:0]        deadtime,
    output logic [NUM_CH-1:0]       pwm_hi,
    output logic [NUM_CH-1:0]       pwm_lo,
    output logic                    period_start
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] dt_sh;
    logic             cnt_max;
    logic             shadow_load;

    assign cnt_max     = (cnt == MAX);
    assign shadow_load = !en || cnt_max;

    // NOTE: all state is updated with non-blocking assignments so every
    // comparison below sees the pre-increment counter of the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            dt_sh        <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= en ? cnt + 1'b1 : '0;
            period_start <= en && cnt_max;
            if (shadow_load) begin
                dt_sh <= deadtime;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WIDTH-1:0] duty_sh;
        logic [WIDTH:0]   lo_thresh;
        logic             hi_q;
        logic             lo_q;

        // NOTE: the sum is one bit wider so duty+dead-time past MAX never wraps
        // back into range; an oversized threshold simply keeps pwm_lo off.
        assign lo_thresh = {1'b0, duty_sh} + {1'b0, dt_sh};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_sh <= '0;
                hi_q    <= 1'b0;
                lo_q    <= 1'b0;
            end else begin
                if (shadow_load) begin
                    duty_sh <= duty[k*WIDTH +: WIDTH];
                end

                if (!en) begin
                    hi_q <= 1'b0;
                end else if (cnt >= duty_sh) begin
                    hi_q <= 1'b0;
                end else if (cnt >= dt_sh) begin
                    hi_q <= 1'b1;
                end

                // Clearing at MAX wins over setting, so duty=MAX with dt=0
                // never produces a one-cycle low-side pulse.
                if (!en) begin
                    lo_q <= 1'b0;
                end else if (cnt_max) begin
                    lo_q <= 1'b0;
                end else if ({1'b0, cnt} >= lo_thresh) begin
                    lo_q <= 1'b1;
                end
            end
        end

        assign pwm_hi[k] = hi_q;
        assign pwm_lo[k] = lo_q;
    end

endmodule

// File: tb/tb_pwm_dt_multi.sv
// Directed and randomised bench for pwm_dt_multi: per-period edge statistics
// plus a cycle-by-cycle reference model derived from the output windows.
module tb_pwm_dt_multi;

    localparam int W   = 12;
    localparam int N   = 3;
    localparam logic [W-1:0] MAX = '1;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [N*W-1:0]   duty;
    logic [W-1:0]     deadtime;
    logic [N-1:0]     pwm_hi;
    logic [N-1:0]     pwm_lo;
    logic             period_start;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_dt_multi #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .duty         (duty),
        .deadtime     (deadtime),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: within a period pwm_hi is 1 after edges dt..duty-1 and
    // pwm_lo is 1 after edges duty+dt..MAX-1 (unbounded integer sum).
    logic [W-1:0] m_cnt;
    logic [W-1:0] m_dt;
    logic [W-1:0] m_duty [N];
    logic [N-1:0] e_hi, e_lo;
    logic         e_ps;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= '0;
            m_dt  <= '0;
            for (int k = 0; k < N; k++) m_duty[k] <= '0;
            e_hi  <= '0;
            e_lo  <= '0;
            e_ps  <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                e_hi[k] <= en && (m_cnt >= m_dt) && (m_cnt < m_duty[k]);
                e_lo[k] <= en && (m_cnt != MAX) &&
                           (int'(m_cnt) >= int'(m_duty[k]) + int'(m_dt));
            end
            e_ps  <= en && (m_cnt == MAX);
            m_cnt <= en ? m_cnt + 12'd1 : '0;
            if (!en || m_cnt == MAX) begin
                m_dt <= deadtime;
                for (int k = 0; k < N; k++) m_duty[k] <= duty[k*W +: W];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("sb_outputs", 32'({pwm_hi, pwm_lo, period_start}), 32'({e_hi, e_lo, e_ps}));
            check("sb_overlap", 32'(pwm_hi & pwm_lo), 32'd0);
        end
    end

    // Per-period statistics; edge index = pre-increment count of the edge.
    int hi_n [N], lo_n [N], hi_r [N], hi_f [N], lo_r [N], lo_f [N], hi_rises [N];
    int ps_n, ps_e;

    task automatic measure_period(input int chg_at, input logic [N*W-1:0] nd, input logic [W-1:0] ndt);
        int guard;
        int e;
        logic [N-1:0] ph, pl;
        guard = 0;
        @(negedge clk);
        while (m_cnt != 12'd1 && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        check("period_sync", 32'(guard < 10000), 32'd1);
        for (int k = 0; k < N; k++) begin
            hi_n[k] = 0; lo_n[k] = 0; hi_rises[k] = 0;
            hi_r[k] = -1; hi_f[k] = -1; lo_r[k] = -1; lo_f[k] = -1;
        end
        ps_n = 0; ps_e = -1;
        ph = '0; pl = '0;
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) @(negedge clk);
            e = (m_cnt == 0) ? 4095 : int'(m_cnt) - 1;
            for (int k = 0; k < N; k++) begin
                if (pwm_hi[k]) hi_n[k]++;
                if (pwm_lo[k]) lo_n[k]++;
                if (pwm_hi[k] && !ph[k]) begin
                    if (hi_r[k] < 0) hi_r[k] = e;
                    hi_rises[k]++;
                end
                if (!pwm_hi[k] && ph[k]) hi_f[k] = e;
                if (pwm_lo[k] && !pl[k] && lo_r[k] < 0) lo_r[k] = e;
                if (!pwm_lo[k] && pl[k]) lo_f[k] = e;
            end
            if (period_start) begin
                ps_n++;
                ps_e = e;
            end
            ph = pwm_hi;
            pl = pwm_lo;
            if (i == chg_at) begin
                duty     = nd;
                deadtime = ndt;
            end
        end
    endtask

    task automatic wait_cnt(input logic [W-1:0] target);
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_cnt != target && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_cnt", 32'(guard < 10000), 32'd1);
    endtask

    function automatic logic [W-1:0] rnd_duty();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return MAX;
            2:       return W'($urandom_range(0, 64));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_dt();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return W'($urandom_range(0, 64));
            2:       return MAX;
            default: return W'($urandom_range(0, 1500));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*W-1:0] nd;
        logic [W-1:0]   ndt;

        rst_n    = 1'b0;
        en       = 1'b0;
        duty     = {12'h010, 12'hFF0, 12'h400};
        deadtime = 12'h02C;
        #3;
        check("reset_hi", 32'(pwm_hi), 32'd0);
        check("reset_lo", 32'(pwm_lo), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b1;

        // Nominal, overflow and duty<=deadtime channels in one period.
        measure_period(-1, duty, deadtime);
        check("t1_hi0_count", hi_n[0], 980);
        check("t1_hi0_rise",  hi_r[0], 12'h02C);
        check("t1_hi0_fall",  hi_f[0], 12'h400);
        check("t1_lo0_count", lo_n[0], 3027);
        check("t1_lo0_rise",  lo_r[0], 12'h42C);
        check("t1_lo0_fall",  lo_f[0], 12'hFFF);
        check("t1_gap",       lo_r[0] - hi_f[0], 44);
        check("t1_ps_count",  ps_n, 1);
        check("t1_ps_edge",   ps_e, 12'hFFF);
        check("t2_hi1_count", hi_n[1], 4036);
        check("t2_hi1_fall",  hi_f[1], 12'hFF0);
        check("t2_lo1_count", lo_n[1], 0);
        check("t3_hi2_count", hi_n[2], 0);
        check("t3_lo2_count", lo_n[2], 4035);
        check("t3_lo2_rise",  lo_r[2], 12'h03C);

        // Mid-period change must not touch the running period.
        measure_period(12'h200, {12'h010, 12'hFF0, 12'h800}, 12'h010);
        check("t4a_hi0_rise",  hi_r[0], 12'h02C);
        check("t4a_hi0_fall",  hi_f[0], 12'h400);
        check("t4a_hi0_rises", hi_rises[0], 1);
        check("t4a_lo0_rise",  lo_r[0], 12'h42C);
        measure_period(-1, duty, deadtime);
        check("t4b_hi0_rise",  hi_r[0], 12'h010);
        check("t4b_hi0_fall",  hi_f[0], 12'h800);
        check("t4b_hi0_count", hi_n[0], 2032);
        check("t4b_hi0_rises", hi_rises[0], 1);
        check("t4b_lo0_rise",  lo_r[0], 12'h810);
        check("t4b_lo0_count", lo_n[0], 2031);
        check("t4b_lo1_count", lo_n[1], 0);
        check("t4b_hi2_count", hi_n[2], 0);

        // en falling mid-period.
        wait_cnt(12'h100);
        check("t5_pre_drop_hi0", 32'(pwm_hi[0]), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("t5_drop_hi", 32'(pwm_hi), 32'd0);
        check("t5_drop_lo", 32'(pwm_lo), 32'd0);
        check("t5_drop_ps", 32'(period_start), 32'd0);
        deadtime = 12'h020;
        repeat (3) @(negedge clk);
        en = 1'b1;
        measure_period(-1, duty, deadtime);
        check("t5_rerun_hi0_rise",  hi_r[0], 12'h020);
        check("t5_rerun_hi0_count", hi_n[0], 2016);
        check("t5_rerun_lo0_rise",  lo_r[0], 12'h820);
        check("t5_rerun_ps_count",  ps_n, 1);
        check("t5_rerun_ps_edge",   ps_e, 12'hFFF);

        // Asynchronous reset mid-period, shadows restart at zero.
        wait_cnt(12'h500);
        check("t5_pre_rst_hi0", 32'(pwm_hi[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_hi", 32'(pwm_hi), 32'd0);
        check("t5_rst_lo", 32'(pwm_lo), 32'd0);
        check("t5_rst_ps", 32'(period_start), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure_period(-1, duty, deadtime);
        check("t5_zero_hi0_count", hi_n[0], 0);
        check("t5_zero_lo0_count", lo_n[0], 4095);
        check("t5_zero_lo0_rise",  lo_r[0], 0);
        check("t5_zero_ps_count",  ps_n, 1);
        measure_period(-1, duty, deadtime);
        check("t5_after_hi0_rise", hi_r[0], 12'h020);
        check("t5_after_hi0_fall", hi_f[0], 12'h800);

        // Random duty/dead-time per period; the reference model checks every cycle.
        for (int p = 0; p < 8; p++) begin
            nd  = {rnd_duty(), rnd_duty(), rnd_duty()};
            ndt = rnd_dt();
            measure_period(int'($urandom_range(0, 4095)), nd, ndt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
